// File: rtl/add_checker.sv
// -----------------------------------------------------------------------------
// add_checker
//
// Checks a registered adder from the receiving side of its stimulus
// interface. Each valid operand pair is turned into a predicted sum. The
// prediction is delayed by LATENCY cycles and then compared with the DUT sum.
// The checker keeps saturating pass/fail counts, captures the first failing
// comparison and can optionally halt on the first failure.
//
// Parameters
//   WIDTH        operand width; sums are WIDTH+1 bits
//   LATENCY      cycles from operand sample to sum sample (1..8)
//   CNT_W        width of the pass/fail counters
//   STOP_ON_FAIL 1: the first mismatch halts checking until clear
//
// Ports
//   clk       clock, posedge active
//   rst_n     asynchronous active-low reset
//   en        operand pair on a/b is valid this cycle
//   a, b      operands
//   sum       DUT result, WIDTH+1 bits
//   clear     synchronous flush of all checker state
//   pass_cnt  matching comparisons (saturating)
//   fail_cnt  mismatching comparisons (saturating)
//   mismatch  one-cycle registered pulse per failed comparison
//   halted    high while halted after a failure
//   busy      running, or a prediction is still in flight
//   ff_valid  first-failure capture is loaded (sticky until clear)
//   ff_exp    expected sum of the first failure
//   ff_got    DUT sum of the first failure
// -----------------------------------------------------------------------------
module add_checker #(
  parameter int WIDTH        = 4,
  parameter int LATENCY      = 1,
  parameter int CNT_W        = 8,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   sum,
  input  logic             clear,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             mismatch,
  output logic             halted,
  output logic             busy,
  output logic             ff_valid,
  output logic [WIDTH:0]   ff_exp,
  output logic [WIDTH:0]   ff_got
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] w_vld_shift;
  logic [LATENCY-1:0] w_vld_nxt;
  logic [WIDTH:0]     r_exp [LATENCY];
  logic [WIDTH:0]     w_exp_new;
  logic               w_cmp;
  logic               w_pass;
  logic               w_fail;
  logic [CNT_W-1:0]   r_pass_cnt;
  logic [CNT_W-1:0]   r_fail_cnt;
  logic               r_mismatch;
  logic               r_ff_valid;
  logic [WIDTH:0]     r_ff_exp;
  logic [WIDTH:0]     r_ff_got;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Full-width prediction: the carry is kept, never truncated.
  assign w_exp_new = {1'b0, a} + {1'b0, b};

  // A comparison needs a valid prediction in the last stage; a halted
  // checker compares nothing.
  assign w_cmp  = r_vld[LATENCY-1] && (r_state != S_HALT);
  assign w_pass = w_cmp && (sum == r_exp[LATENCY-1]);
  assign w_fail = w_cmp && (sum != r_exp[LATENCY-1]);

  // Valid flags as they would look after this edge's shift.
  always_comb begin
    w_vld_shift    = '0;
    w_vld_shift[0] = en;
    for (int i = 1; i < LATENCY; i++) begin
      w_vld_shift[i] = r_vld[i-1];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (en) w_state_nxt = S_RUN;
        S_RUN: begin
          if (STOP_ON_FAIL && w_fail)   w_state_nxt = S_HALT;
          else if (w_vld_shift == '0)   w_state_nxt = S_IDLE;
        end
        S_HALT:  w_state_nxt = S_HALT;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Clearing, entering HALT and staying in HALT all flush the pipeline:
  // in-flight pairs are dropped and only bubbles are pushed while halted.
  always_comb begin
    w_vld_nxt = w_vld_shift;
    if (clear || (w_state_nxt == S_HALT)) begin
      w_vld_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_vld      <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_mismatch <= 1'b0;
      r_ff_valid <= 1'b0;
      r_ff_exp   <= '0;
      r_ff_got   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vld   <= w_vld_nxt;
      if (clear) begin
        r_pass_cnt <= '0;
        r_fail_cnt <= '0;
        r_mismatch <= 1'b0;
        r_ff_valid <= 1'b0;
        r_ff_exp   <= '0;
        r_ff_got   <= '0;
      end else begin
        r_mismatch <= w_fail;
        if (w_pass) r_pass_cnt <= sat_inc(r_pass_cnt);
        if (w_fail) r_fail_cnt <= sat_inc(r_fail_cnt);
        if (w_fail && !r_ff_valid) begin
          r_ff_valid <= 1'b1;
          r_ff_exp   <= r_exp[LATENCY-1];
          r_ff_got   <= sum;
        end
      end
    end
  end

  // Prediction data only matters where its valid flag is set, so it needs
  // no reset or flush.
  always_ff @(posedge clk) begin
    r_exp[0] <= w_exp_new;
    for (int i = 1; i < LATENCY; i++) begin
      r_exp[i] <= r_exp[i-1];
    end
  end

  assign pass_cnt = r_pass_cnt;
  assign fail_cnt = r_fail_cnt;
  assign mismatch = r_mismatch;
  assign halted   = (r_state == S_HALT);
  assign busy     = (r_state == S_RUN) || (|r_vld);
  assign ff_valid = r_ff_valid;
  assign ff_exp   = r_ff_exp;
  assign ff_got   = r_ff_got;

endmodule

// File: tb/tb_add_checker.sv
// -----------------------------------------------------------------------------
// tb_add_checker
//
// Directed bench for add_checker. Three instances share one stimulus stream:
//   u0  default parameters (LATENCY=1, CNT_W=8, STOP_ON_FAIL=0)
//   u1  CNT_W=2, STOP_ON_FAIL=1
//   u2  LATENCY=3
// A behavioural registered adder (with an optional corrupted result) feeds
// u0/u1, and a three-deep delay of the true sum feeds u2.
// -----------------------------------------------------------------------------
module tb_add_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       corrupt = 1'b0;
  logic [4:0] cval = '0;
  logic [4:0] sum1, d1, d2, d3;

  logic [7:0] pass0, fail0;
  logic       mm0, halt0, busy0, ffv0;
  logic [4:0] ffe0, ffg0;
  logic [1:0] pass1, fail1;
  logic       mm1, halt1, busy1, ffv1;
  logic [4:0] ffe1, ffg1;
  logic [7:0] pass2, fail2;
  logic       mm2, halt2, busy2, ffv2;
  logic [4:0] ffe2, ffg2;

  int n_chk  = 0;
  int n_fail = 0;
  int mmc0   = 0;

  always #5 clk = ~clk;

  // Reference adder: result registered on the edge the operands are applied.
  always @(posedge clk) begin
    sum1 <= corrupt ? cval : ({1'b0, a} + {1'b0, b});
    d1   <= {1'b0, a} + {1'b0, b};
    d2   <= d1;
    d3   <= d2;
  end

  add_checker u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .sum(sum1), .clear(clear),
    .pass_cnt(pass0), .fail_cnt(fail0), .mismatch(mm0), .halted(halt0),
    .busy(busy0), .ff_valid(ffv0), .ff_exp(ffe0), .ff_got(ffg0)
  );

  add_checker #(.CNT_W(2), .STOP_ON_FAIL(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .sum(sum1), .clear(clear),
    .pass_cnt(pass1), .fail_cnt(fail1), .mismatch(mm1), .halted(halt1),
    .busy(busy1), .ff_valid(ffv1), .ff_exp(ffe1), .ff_got(ffg1)
  );

  add_checker #(.LATENCY(3)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .sum(d3), .clear(clear),
    .pass_cnt(pass2), .fail_cnt(fail2), .mismatch(mm2), .halted(halt2),
    .busy(busy2), .ff_valid(ffv2), .ff_exp(ffe2), .ff_got(ffg2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic e, input logic [3:0] ia, input logic [3:0] ib,
                      input logic c, input logic [4:0] cv);
    en = e; a = ia; b = ib; corrupt = c; cval = cv;
    @(posedge clk);
    #1;
    mmc0 += int'(mm0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 1'b0, 5'd0);
  endtask

  // Clear with a valid pair present: that pair must be discarded.
  task automatic do_clear();
    clear = 1'b1; en = 1'b1; a = 4'd1; b = 4'd1; corrupt = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0; en = 1'b0;
    mmc0 = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pass", 32'(pass0), 0);
    chk("rst_fail", 32'(fail0), 0);
    chk("rst_mm", 32'(mm0), 0);
    chk("rst_halt", 32'(halt0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_ffv", 32'(ffv0), 0);
    chk("rst_ffe", 32'(ffe0), 0);
    chk("rst_ffg", 32'(ffg0), 0);
    #2 rst_n = 1'b1;

    // 4+4 three times, DUT correct.
    mmc0 = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 4'd4, 4'd4, 1'b0, 5'd0);
    chk("s1_busy_tail", 32'(busy0), 1);
    idle(1);
    chk("s1_pass", 32'(pass0), 3);
    chk("s1_fail", 32'(fail0), 0);
    chk("s1_busy_drop", 32'(busy0), 0);
    chk("s1_no_mm", 32'(mmc0), 0);
    chk("s1_u1_pass", 32'(pass1), 3);
    idle(1);
    do_clear();
    idle(2);
    chk("clr_discard", 32'(pass0), 0);
    chk("clr_busy", 32'(busy0), 0);

    // 15+15 correct, then 15+15 truncated to 14.
    step(1'b1, 4'd15, 4'd15, 1'b0, 5'd0);
    step(1'b1, 4'd15, 4'd15, 1'b1, 5'd14);
    idle(1);
    chk("s2_mm_pulse", 32'(mm0), 1);
    chk("s2_pass", 32'(pass0), 1);
    chk("s2_fail", 32'(fail0), 1);
    chk("s2_ffv", 32'(ffv0), 1);
    chk("s2_ffe", 32'(ffe0), 30);
    chk("s2_ffg", 32'(ffg0), 14);
    idle(1);
    chk("s2_mm_one_cycle", 32'(mm0), 0);
    do_clear();
    idle(1);
    chk("s2_clr_ffv", 32'(ffv0), 0);
    chk("s2_clr_ffe", 32'(ffe0), 0);

    // 4+4, 3+4 (DUT forced to 9), 5+4.
    mmc0 = 0;
    step(1'b1, 4'd4, 4'd4, 1'b0, 5'd0);
    step(1'b1, 4'd3, 4'd4, 1'b1, 5'd9);
    step(1'b1, 4'd5, 4'd4, 1'b0, 5'd0);
    idle(2);
    chk("s3_pass", 32'(pass0), 2);
    chk("s3_fail", 32'(fail0), 1);
    chk("s3_pulses", 32'(mmc0), 1);
    chk("s3_ffe", 32'(ffe0), 7);
    chk("s3_ffg", 32'(ffg0), 9);
    do_clear();

    // Six correct pairs: the 2-bit counter saturates.
    for (int i = 0; i < 6; i++) step(1'b1, 4'(i), 4'd2, 1'b0, 5'd0);
    idle(2);
    chk("s4_sat", 32'(pass1), 3);
    chk("s4_sat_fail", 32'(fail1), 0);
    chk("s4_u0_pass", 32'(pass0), 6);
    do_clear();

    // Five pairs, second one wrong: u1 halts.
    step(1'b1, 4'd1, 4'd1, 1'b0, 5'd0);
    step(1'b1, 4'd2, 4'd2, 1'b1, 5'd0);
    step(1'b1, 4'd3, 4'd3, 1'b0, 5'd0);
    step(1'b1, 4'd4, 4'd4, 1'b0, 5'd0);
    step(1'b1, 4'd5, 4'd5, 1'b0, 5'd0);
    idle(2);
    chk("s5_halted", 32'(halt1), 1);
    chk("s5_fail", 32'(fail1), 1);
    chk("s5_pass", 32'(pass1), 1);
    chk("s5_busy", 32'(busy1), 0);
    chk("s5_u0_pass", 32'(pass0), 4);
    chk("s5_u0_fail", 32'(fail0), 1);
    do_clear();
    chk("s5_clr_halt", 32'(halt1), 0);
    chk("s5_clr_pass", 32'(pass1), 0);
    chk("s5_clr_fail", 32'(fail1), 0);
    chk("s5_clr_ffv", 32'(ffv1), 0);

    // LATENCY=3 with en 1,0,1,1.
    step(1'b1, 4'd1, 4'd1, 1'b0, 5'd0);
    step(1'b0, 4'd9, 4'd9, 1'b0, 5'd0);
    step(1'b1, 4'd2, 4'd3, 1'b0, 5'd0);
    step(1'b1, 4'd7, 4'd8, 1'b0, 5'd0);
    idle(4);
    chk("s6_pass", 32'(pass2), 3);
    chk("s6_fail", 32'(fail2), 0);
    chk("s6_busy", 32'(busy2), 0);
    do_clear();

    // Asynchronous reset with pairs in flight.
    step(1'b1, 4'd2, 4'd2, 1'b0, 5'd0);
    step(1'b1, 4'd3, 4'd3, 1'b0, 5'd0);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("s7_rst_pass", 32'(pass0), 0);
    chk("s7_rst_busy0", 32'(busy0), 0);
    chk("s7_rst_busy2", 32'(busy2), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    idle(4);
    chk("s7_u2_pass", 32'(pass2), 0);
    chk("s7_u2_fail", 32'(fail2), 0);
    chk("s7_u0_fail", 32'(fail0), 0);
    step(1'b1, 4'd6, 4'd1, 1'b0, 5'd0);
    idle(1);
    chk("s7_resume", 32'(pass0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
